// File: rtl/maxpool_pkg.sv
// Shared constants and helpers for the 2x2 stride-2 max-pooling block.
// Default sample width and frame geometry live here together with the counter-width function.
package maxpool_pkg;

    localparam int DEFAULT_DW   = 8;
    localparam int DEFAULT_COLS = 32;
    localparam int DEFAULT_ROWS = 32;

    // Ceiling log2, never below 1 so that a depth of 1 still yields a legal vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// Single-port line buffer that holds one row of horizontal pair maxima.
// Writes are synchronous and reads are combinational from the same address.
module maxpool_line_buffer
    import maxpool_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_COLS / 2,
    parameter int AW    = clog2_min1(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Entries are always written on the even row before the odd row reads them, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/maxpool_2d.sv
// 2x2 stride-2 signed max pooling over a raster-ordered frame, one pooled sample per 2x2 window.
// Define MAXPOOL_2D_RELU_EN to clamp negative pooled results to zero before they are registered.
module maxpool_2d
    import maxpool_pkg::*;
#(
    parameter int DW   = DEFAULT_DW,
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iEN,
    input  logic [DW-1:0] iDATA,
    output logic [DW-1:0] oDATA,
    output logic          oVALID,
    output logic          oLAST
);

    localparam int CW   = clog2_min1(COLS);
    localparam int RW   = clog2_min1(ROWS);
    localparam int HALF = COLS / 2;
    localparam int AW   = clog2_min1(HALF);

    // Handshake: a sample is accepted on every rising edge with iEN high (no backpressure);
    // oVALID is a one-cycle pulse, the edge after the accepted sample that closes a window.
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [DW-1:0] pair_q, pair_d;
    logic signed [DW-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic signed [DW-1:0] in_s;
    logic signed [DW-1:0] pair_max;
    logic signed [DW-1:0] pool_max;
    logic signed [DW-1:0] pool_out;
    logic signed [DW-1:0] lb_rdata;
    logic [AW-1:0]        lb_addr;
    logic                 col_odd;
    logic                 row_odd;
    logic                 lb_we;
    logic                 col_wrap;
    logic                 row_wrap;

    assign in_s     = $signed(iDATA);
    assign col_odd  = col_q[0];
    assign row_odd  = row_q[0];
    assign col_wrap = (col_q == CW'(COLS - 1));
    assign row_wrap = (row_q == RW'(ROWS - 1));
    assign lb_addr  = AW'(col_q >> 1);
    assign lb_we    = iEN && !iCLR && col_odd && !row_odd;

    assign pair_max = (pair_q > in_s) ? pair_q : in_s;
    assign pool_max = (pair_max > lb_rdata) ? pair_max : lb_rdata;

`ifdef MAXPOOL_2D_RELU_EN
    assign pool_out = pool_max[DW-1] ? '0 : pool_max;
`else
    assign pool_out = pool_max;
`endif

    maxpool_line_buffer #(
        .DW    (DW),
        .DEPTH (HALF),
        .AW    (AW)
    ) u_line_buffer (
        .clk_i   (iCLK),
        .we_i    (lb_we),
        .addr_i  (lb_addr),
        .wdata_i (pair_max),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (iCLR) begin
            // The sample presented with a clear is discarded, as is any window it would close.
            col_d  = '0;
            row_d  = '0;
            pair_d = '0;
        end else if (iEN) begin
            if (!col_odd) begin
                pair_d = in_s;
            end
            if (col_odd && row_odd) begin
                valid_d = 1'b1;
                data_d  = pool_out;
                last_d  = col_wrap && row_wrap;
            end
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign oDATA  = data_q;
    assign oVALID = valid_q;
    assign oLAST  = last_q;

endmodule

// File: doc/maxpool_2d.md
MAXPOOL_2D -- requirements
Module: maxpool_2d

Interface
REQ-001 SHALL have parameter DW, default 8: sample width in bits, signed two's complement.
REQ-002 SHALL have parameter COLS, default 32: input row length in samples; even, >=2.
REQ-003 SHALL have parameter ROWS, default 32: input frame height in rows; even, >=2.
REQ-004 SHALL have port iCLK, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port iRSTn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port iCLR, input, 1: synchronous frame abort and clear.
REQ-007 SHALL have port iEN, input, 1: iDATA valid this cycle.
REQ-008 SHALL have port iDATA, input, DW: input sample, raster order, row-major.
REQ-009 SHALL have port oDATA, output, DW: pooled sample.
REQ-010 SHALL have port oVALID, output, 1: single-cycle pulse, oDATA valid.
REQ-011 SHALL have port oLAST, output, 1: high with oVALID on the last pooled sample of a frame.

Function
REQ-012 SHALL perform 2x2 max pooling at stride 2, giving (ROWS/2)*(COLS/2) outputs per frame.
REQ-013 SHALL keep a column counter (0..COLS-1) and a row counter (0..ROWS-1), both advancing only on iEN.
REQ-014 SHALL wrap the column counter to 0 after COLS-1 and advance the row counter; row counter wraps to 0 after ROWS-1 (next frame, no idle cycle).
REQ-015 SHALL hold the even-column sample in a pair register; on the odd column, compute pair max = max(pair register, iDATA).
REQ-016 SHALL, on even rows, write pair max into line buffer entry col/2 (depth COLS/2, width DW).
REQ-017 SHALL, on odd rows at odd column, compute max(pair max, line buffer[col/2]) and register it to oDATA.
REQ-018 SHALL assert oVALID exactly one cycle after the iEN cycle carrying sample (odd row, odd column); latency 1 cycle.
REQ-019 SHALL assert oLAST with the oVALID for input sample (ROWS-1, COLS-1).
REQ-020 SHALL use signed comparison; on equal values either operand is acceptable (identical result).
REQ-021 SHALL hold oDATA between valid pulses; oVALID/oLAST low otherwise.
REQ-022 SHALL tolerate arbitrary iEN gaps: state is frozen while iEN is low; results depend only on the accepted sample sequence.
REQ-023 SHALL give iCLR priority over iEN: counters to 0, pair register to 0, oVALID/oLAST to 0 next cycle; the current sample is discarded; line buffer contents need not be cleared (always overwritten before read).
REQ-024 SHALL let a pooled result still in flight when iCLR arrives be dropped (no oVALID after a clear).

Reset
REQ-025 SHALL, while iRSTn is low at a rising edge, set counters 0, pair register 0, oDATA 0, oVALID 0, oLAST 0.
REQ-026 SHALL give iRSTn priority over iCLR and iEN; a reset mid-frame restarts at sample (0,0).

Configuration
REQ-027 SHALL, with macro MAXPOOL_2D_RELU_EN defined, clamp negative pooled results to 0 before registering to oDATA (fused ReLU).
REQ-028 SHALL, without MAXPOOL_2D_RELU_EN, output the signed max unmodified; timing and handshakes identical in both builds.

Structure
REQ-029 SHALL place the default DW/COLS/ROWS constants and the counter-width function (ceil log2) in shared package maxpool_pkg.
REQ-030 SHALL implement the line buffer as sub-module maxpool_line_buffer (single-port, synchronous write, combinational read, depth COLS/2).

Verification
REQ-031 SHALL verify 4x4 frame 1..16 raster, DW=8, continuous iEN -> oDATA 6,8,14,16 with oVALID one cycle after samples 6,8,14,16; oLAST only with 16.
REQ-032 SHALL verify all-negative 4x4 frame (-16..-1) -> -11,-9,-3,-1 without macro; 0,0,0,0 with MAXPOOL_2D_RELU_EN.
REQ-033 SHALL verify the REQ-031 frame with iEN low every other cycle -> same four outputs, each one cycle after its trigger sample.
REQ-034 SHALL verify iCLR asserted on sample 7 of a frame, then a fresh 4x4 frame of all 5 -> four outputs of 5, none before.
REQ-035 SHALL verify iRSTn low for one cycle mid-frame, then two back-to-back 4x4 frames -> 8 outputs, oLAST on 4th and 8th.
REQ-036 SHALL verify -128 and 127 in one window (DW=8) -> 127 (signed compare, no overflow).
